// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side initiator for the 4-bit combinational ALU.
// Accepts register-based commands, drives the ALU for ALU_WAIT cycles, writes
// the result back into a 4 x 4-bit register file and returns it on a response
// channel.
//
// Optional feature: define ALU_CMD_SEQUENCER_CNT_EN to add op_count[7:0], a
// saturating count of error-free response handshakes.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | ALU inputs driven, waiting ALU_WAIT cycles before capturing alu_c
// RESP  | response presented, held until rsp_ready
module alu_cmd_sequencer #(
    parameter int          ALU_WAIT    = 1,
    parameter logic [3:0]  DIV0_RESULT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_a,
    input  logic [1:0] cmd_src_b,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_dst,
    output logic       rsp_err
`ifdef ALU_CMD_SEQUENCER_CNT_EN
    ,
    output logic [7:0] op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Down-counter reload; terminal count zero marks the capture edge.
    localparam logic [1:0] WAIT_LOAD = 2'(ALU_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] regs [4];
    logic [3:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] dst_q;
    logic [1:0] wait_cnt;

    logic accept;
    logic op_alu;
    logic div0;
    logic issue_go;
    logic wait_done;
    logic rsp_hs;

    assign accept    = cmd_valid && cmd_ready;
    assign op_alu    = (cmd_op >= 4'd1) && (cmd_op <= 4'd8);
    assign div0      = (cmd_op == 4'd4) && (regs[cmd_src_b] == 4'd0);
    assign issue_go  = op_alu && !div0;
    assign wait_done = (wait_cnt == 2'd0);
    assign rsp_hs    = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs; ALU inputs are zero outside ISSUE.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_opcode = 4'd0;
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    state_nxt = issue_go ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_opcode = op_q;
                alu_a      = a_q;
                alu_b      = b_q;
                if (wait_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, special-case resolution, ALU result capture and writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 4'd0;
            end
            op_q     <= 4'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            dst_q    <= 2'd0;
            wait_cnt <= 2'd0;
            rsp_data <= 4'd0;
            rsp_dst  <= 2'd0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        dst_q    <= cmd_dst;
                        a_q      <= regs[cmd_src_a];
                        b_q      <= regs[cmd_src_b];
                        wait_cnt <= WAIT_LOAD;
                        rsp_dst  <= cmd_dst;
                        if (cmd_op == 4'd0) begin
                            rsp_data      <= cmd_imm;
                            rsp_err       <= 1'b0;
                            regs[cmd_dst] <= cmd_imm;
                        end else if (div0) begin
                            rsp_data      <= DIV0_RESULT;
                            rsp_err       <= 1'b1;
                            regs[cmd_dst] <= DIV0_RESULT;
                        end else if (op_alu) begin
                            rsp_err <= 1'b0;
                        end else begin
                            rsp_data <= 4'd0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (wait_done) begin
                        rsp_data    <= alu_c;
                        regs[dst_q] <= alu_c;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_CMD_SEQUENCER_CNT_EN
    // Saturating count of error-free response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'd0;
        end else if (rsp_hs && !rsp_err && (op_count != 8'hFF)) begin
            op_count <= op_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed test-plan sequence
// followed by randomized commands compared against a register-file model.
module tb_alu_cmd_sequencer;

    localparam int         ALU_WAIT    = 1;
    localparam logic [3:0] DIV0_RESULT = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [3:0] cmd_imm;
    logic [3:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [1:0] rsp_dst;
    logic       rsp_err;
`ifdef ALU_CMD_SEQUENCER_CNT_EN
    logic [7:0] op_count;
    int         m_cnt;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] m_regs [4];
    logic [3:0] got;

    alu_cmd_sequencer #(.ALU_WAIT(ALU_WAIT), .DIV0_RESULT(DIV0_RESULT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_imm    (cmd_imm),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_dst    (rsp_dst),
        .rsp_err    (rsp_err)
`ifdef ALU_CMD_SEQUENCER_CNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    // 4-bit ALU arithmetic: opcodes 1..8, anything else gives 0.
    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a * b;
            4'd4: return (b == 4'd0) ? 4'd0 : a / b;
            4'd5: return a & b;
            4'd6: return a ^ b;
            4'd7: return ~a;
            4'd8: return a | b;
            default: return 4'd0;
        endcase
    endfunction

    // Behavioural ALU attached to the sequencer.
    always_comb alu_c = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic junk_cmd();
        cmd_op    = 4'($urandom);
        cmd_dst   = 2'($urandom);
        cmd_src_a = 2'($urandom);
        cmd_src_b = 2'($urandom);
        cmd_imm   = 4'($urandom);
    endtask

    // Issue one command, follow it to its response and check against the model.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [3:0] imm, input int hold,
                          output logic [3:0] data_out);
        logic [3:0] e_res;
        logic       e_err;
        logic       e_wb;
        logic       e_issue;
        int         e_lat;
        int         lat;
        e_issue = (op >= 4'd1) && (op <= 4'd8) && !((op == 4'd4) && (m_regs[sb] == 4'd0));
        if (op == 4'd0) begin
            e_res = imm; e_err = 1'b0; e_wb = 1'b1;
        end else if ((op == 4'd4) && (m_regs[sb] == 4'd0)) begin
            e_res = DIV0_RESULT; e_err = 1'b1; e_wb = 1'b1;
        end else if (op <= 4'd8) begin
            e_res = alu_fn(op, m_regs[sa], m_regs[sb]); e_err = 1'b0; e_wb = 1'b1;
        end else begin
            e_res = 4'd0; e_err = 1'b1; e_wb = 1'b0;
        end
        e_lat = e_issue ? 1 + ALU_WAIT : 1;

        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        junk_cmd();

        lat = 1;
        while (!rsp_valid && lat < 16) begin
            if (e_issue) begin
                check_eq("issue_opcode", alu_opcode, op);
                check_eq("issue_a", alu_a, m_regs[sa]);
                check_eq("issue_b", alu_b, m_regs[sb]);
            end else begin
                check_eq("noissue_opcode", alu_opcode, 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        check_eq("rsp_latency", lat, e_lat);
        check_eq("resp_alu_opcode", alu_opcode, 0);
        check_eq("rsp_data", rsp_data, e_res);
        check_eq("rsp_dst", rsp_dst, dst);
        check_eq("rsp_err", rsp_err, e_err);
        check_eq("cmd_ready_busy", cmd_ready, 0);

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            junk_cmd();
            @(posedge clk); #1;
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_data", rsp_data, e_res);
            check_eq("hold_dst", rsp_dst, dst);
            check_eq("hold_err", rsp_err, e_err);
            check_eq("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_drop", rsp_valid, 0);
        check_eq("cmd_ready_back", cmd_ready, 1);

        if (e_wb) m_regs[dst] = e_res;
`ifdef ALU_CMD_SEQUENCER_CNT_EN
        if (!e_err && m_cnt < 255) m_cnt++;
        check_eq("op_count", op_count, m_cnt);
`endif
        data_out = e_res;
        data_out = rsp_data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_dst"}, rsp_dst, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
        check_eq({tag, "_alu_opcode"}, alu_opcode, 0);
        check_eq({tag, "_alu_a"}, alu_a, 0);
        check_eq({tag, "_alu_b"}, alu_b, 0);
`ifdef ALU_CMD_SEQUENCER_CNT_EN
        check_eq({tag, "_op_count"}, op_count, 0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = 4'd0; cmd_dst = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 4'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
`ifdef ALU_CMD_SEQUENCER_CNT_EN
        m_cnt = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed test-plan sequence.
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 4'd5, 0, got); check_eq("plan_ld5", got, 5);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 4'd3, 0, got); check_eq("plan_ld3", got, 3);
        do_cmd(4'd1, 2'd2, 2'd0, 2'd1, 4'd0, 0, got); check_eq("plan_add", got, 8);
        do_cmd(4'd3, 2'd3, 2'd0, 2'd1, 4'd0, 0, got); check_eq("plan_mul", got, 4'hF);
        do_cmd(4'd2, 2'd3, 2'd1, 2'd0, 4'd0, 0, got); check_eq("plan_sub", got, 4'hE);
        do_cmd(4'd7, 2'd3, 2'd0, 2'd2, 4'd0, 0, got); check_eq("plan_not", got, 4'hA);
        do_cmd(4'd0, 2'd3, 2'd0, 2'd0, 4'd0, 0, got); check_eq("plan_ld0", got, 0);
        do_cmd(4'd4, 2'd2, 2'd0, 2'd3, 4'd0, 0, got); check_eq("plan_div0", got, 4'hF);
        check_eq("plan_div0_err", rsp_err, 1);
        do_cmd(4'd8, 2'd2, 2'd2, 2'd2, 4'd0, 0, got); check_eq("plan_r2_readback", got, 4'hF);
        do_cmd(4'd12, 2'd1, 2'd0, 2'd0, 4'd9, 0, got); check_eq("plan_illegal", got, 0);
        do_cmd(4'd1, 2'd0, 2'd1, 2'd1, 4'd0, 0, got); check_eq("plan_r1_kept", got, 6);
        do_cmd(4'd6, 2'd1, 2'd0, 2'd2, 4'd0, 5, got); check_eq("plan_hold_xor", got, 4'h9);

        // Reset in the middle of ISSUE: no writeback, everything cleared.
        cmd_op = 4'd1; cmd_dst = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("midreset_issue_opcode", alu_opcode, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
`ifdef ALU_CMD_SEQUENCER_CNT_EN
        m_cnt = 0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            do_cmd(4'd8, 2'(r), 2'(r), 2'(r), 4'd0, 0, got);
            check_eq("midreset_reg_zero", got, 0);
        end

        // Randomized commands against the model.
        for (int n = 0; n < 300; n++) begin
            int         sel;
            logic [3:0] op;
            sel = $urandom_range(0, 9);
            if (sel < 2)      op = 4'd0;
            else if (sel < 8) op = 4'($urandom_range(1, 8));
            else              op = 4'($urandom_range(9, 15));
            do_cmd(op, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
                   $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the team's combinational 4-bit ALU (opcode/a/b in, c out; opcodes 1..8 = add, sub, mul, div, and, xor, not-a, or; any other opcode yields 0).
- Accepts register-based commands over a valid/ready handshake and holds a 4-entry x 4-bit register file.
- Drives the ALU's opcode/a/b, captures its result, writes it back, and returns it on a valid/ready response channel.
- Sits between a host/test controller and the ALU instance.

Parameters:
- ALU_WAIT, 1, cycles the ALU inputs are held before capturing alu_c (legal 1..4; >1 supports a registered ALU).
- DIV0_RESULT, 4'hF, result returned and written back for divide with b==0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  0 = load immediate; 1..8 = ALU opcode; 9..15 = illegal.
- cmd_dst  in  2  destination register index.
- cmd_src_a  in  2  operand A register index.
- cmd_src_b  in  2  operand B register index.
- cmd_imm  in  4  immediate value for op 0.
- alu_opcode  out  4  to ALU opcode.
- alu_a  out  4  to ALU a.
- alu_b  out  4  to ALU b.
- alu_c  in  4  from ALU c.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  4  result value.
- rsp_dst  out  2  register written, or addressed for illegal ops.
- rsp_err  out  1  1 = divide-by-zero or illegal opcode.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; all four registers are cleared to 0.
  - alu_opcode, alu_a, alu_b, rsp_data, rsp_dst, rsp_err, rsp_valid go to 0; cmd_ready is 1 after reset.
  - Reset mid-operation aborts the operation with no writeback.
- FSM states: IDLE, ISSUE, RESP.
  - cmd_ready = (state==IDLE), decoded from the state register.
- IDLE:
  - On cmd_valid&&cmd_ready, register op/dst/src_a/src_b/imm.
  - Op 1..8 with no divide-by-zero: go to ISSUE.
  - Otherwise: go directly to RESP.
- Special cases, resolved in the accept cycle:
  - Op 0: result = imm, written to dst; rsp_err 0.
  - Op 4 with reg[src_b]==0: ALU is not issued; result = DIV0_RESULT, written to dst; rsp_err 1.
  - Op 9..15: no writeback; rsp_data 0; rsp_err 1.
- ISSUE:
  - Drive alu_opcode = op, alu_a = reg[src_a], alu_b = reg[src_b] for exactly ALU_WAIT cycles.
  - Operands are sampled from the register file at accept time and held stable.
  - At the final ISSUE edge: capture alu_c into rsp_data, write reg[dst] = alu_c, go to RESP.
- Outside ISSUE: alu_opcode = 0, alu_a = 0, alu_b = 0, so the ALU outputs 0.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_dst and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake go to IDLE and drop rsp_valid.
- Latency, ALU_WAIT=1, ALU op:
  - Accept at edge N; ISSUE during cycle N..N+1; rsp_valid high from edge N+2.
  - With rsp_ready tied high, throughput is 1 command per 3 cycles.
- Latency, op 0 / div-by-zero / illegal: rsp_valid high from edge N+1.
- Arithmetic: all results are 4-bit, taken as the ALU returns them (add/sub/mul mod 16; div truncates).
- Hazards:
  - dst may equal src_a or src_b; operands use pre-write values.
  - A following command observes the written value, since operation is strictly sequential.
- cmd_* is ignored whenever cmd_ready is 0.

Optional Feature:
- Macro ALU_CMD_SEQUENCER_CNT_EN adds output op_count[7:0].
  - Reset value 0.
  - Increments on each rsp_valid&&rsp_ready handshake with rsp_err==0.
  - Saturates at 255.
- Without the macro, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset, then op0 dst0 imm5, op0 dst1 imm3 -> rsp_data 5 then 3, rsp_err 0, rsp_valid one cycle after each accept.
- op1 dst2 a=r0 b=r1 -> during ISSUE alu_opcode=1, alu_a=5, alu_b=3; rsp_data 8, rsp_dst 2, rsp_valid at accept+2.
- op3 dst3 r0*r1 -> rsp_data 4'hF; op2 dst3 r1-r0 -> rsp_data 4'hE; op7 dst3 a=r0 -> rsp_data 4'hA.
- op0 dst3 imm0, then op4 dst2 a=r0 b=r3 -> alu_opcode stays 0, rsp_data 4'hF, rsp_err 1, r2 then reads back F.
- op12 dst1 -> rsp_err 1, rsp_data 0; next op1 dst0 r1+r1 -> 6, proving r1 unchanged.
- rsp_ready held low 5 cycles -> rsp_valid/data/dst/err stable, cmd_ready 0, cmd_valid ignored.
- rst_n low mid-ISSUE -> all outputs 0, registers read back 0.
